note_voice_bank: RTL and testbench

Parametrised multi-voice tone generator for the synthesiser datapath. Each voice takes a 4-bit note code (1 = low C … 13 = high C) plus an octave shift, looks up the period divider for the selected board clock (10 MHz or 12 MHz), and runs its own counter to produce a 50 % duty square wave. It also produces a registered mix count of all voices. It sits between the keypad/sequencer note sources and the audio output stage (PWM/DAC).

---
 rtl/note_voice_bank.sv | 142 ++++++++++++++
 tb/tb_note_voice_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_voice_bank.sv
// Multi-voice square-wave tone generator: each voice divides the board clock by a
// note/octave-dependent half period, and a registered popcount of all waves is provided.
module note_voice_bank #(
  parameter int NUM_VOICES = 4,
  parameter int OCT_W      = 2,
  localparam int MIX_W     = $clog2(NUM_VOICES + 1)
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          en,
  input  logic                          is_FPGA,
  input  logic [4*NUM_VOICES-1:0]       note,
  input  logic [OCT_W*NUM_VOICES-1:0]   octave,
  output logic [NUM_VOICES-1:0]         wave,
  output logic [NUM_VOICES-1:0]         active,
  output logic [MIX_W-1:0]              mix
);

  function automatic logic [15:0] f_div10(input logic [3:0] code);
    case (code)
      4'd1:    f_div10 = 16'd38223;
      4'd2:    f_div10 = 16'd36077;
      4'd3:    f_div10 = 16'd34052;
      4'd4:    f_div10 = 16'd32141;
      4'd5:    f_div10 = 16'd30337;
      4'd6:    f_div10 = 16'd28635;
      4'd7:    f_div10 = 16'd27027;
      4'd8:    f_div10 = 16'd25511;
      4'd9:    f_div10 = 16'd24079;
      4'd10:   f_div10 = 16'd22727;
      4'd11:   f_div10 = 16'd21452;
      4'd12:   f_div10 = 16'd20248;
      4'd13:   f_div10 = 16'd19111;
      default: f_div10 = 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] f_div12(input logic [3:0] code);
    case (code)
      4'd1:    f_div12 = 16'd45868;
      4'd2:    f_div12 = 16'd43292;
      4'd3:    f_div12 = 16'd40862;
      4'd4:    f_div12 = 16'd38569;
      4'd5:    f_div12 = 16'd36404;
      4'd6:    f_div12 = 16'd34362;
      4'd7:    f_div12 = 16'd32432;
      4'd8:    f_div12 = 16'd30613;
      4'd9:    f_div12 = 16'd28895;
      4'd10:   f_div12 = 16'd27272;
      4'd11:   f_div12 = 16'd25742;
      4'd12:   f_div12 = 16'd24298;
      4'd13:   f_div12 = 16'd22933;
      default: f_div12 = 16'd0;
    endcase
  endfunction

  logic [NUM_VOICES-1:0] w_wave;
  logic [NUM_VOICES-1:0] w_active;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      logic [3:0]       w_code_in;
      logic [3:0]       w_eff;
      logic [OCT_W-1:0] w_oct_in;
      logic [15:0]      w_div;
      logic [15:0]      w_half_raw;
      logic [15:0]      w_half;
      logic             w_load;
      logic             w_tc;

      logic [3:0]       r_note;
      logic [OCT_W-1:0] r_oct;
      logic             r_sel;
      logic [15:0]      r_cnt;
      logic             r_wave;

      assign w_code_in = note[4*gi +: 4];
      assign w_oct_in  = octave[OCT_W*gi +: OCT_W];
      assign w_eff     = (en && (w_code_in >= 4'd1) && (w_code_in <= 4'd13)) ? w_code_in : 4'd0;

      // Divider is looked up from the latched settings so a running voice is self-consistent.
      assign w_div      = r_sel ? f_div12(r_note) : f_div10(r_note);
      assign w_half_raw = (w_div >> r_oct) >> 1;
      assign w_half     = (w_half_raw == 16'd0) ? 16'd1 : w_half_raw;

      assign w_load = (w_eff != r_note) || (w_oct_in != r_oct) || (is_FPGA != r_sel);
      assign w_tc   = (r_cnt == (w_half - 16'd1));

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          r_note <= 4'd0;
          r_oct  <= '0;
          r_sel  <= 1'b0;
          r_cnt  <= 16'd0;
          r_wave <= 1'b0;
        end else if (w_load) begin
          // A load always restarts the phase, even if the counter was at terminal count.
          r_note <= w_eff;
          r_oct  <= w_oct_in;
          r_sel  <= is_FPGA;
          r_cnt  <= 16'd0;
          r_wave <= 1'b0;
        end else if (r_note == 4'd0) begin
          r_cnt  <= 16'd0;
          r_wave <= 1'b0;
        end else if (w_tc) begin
          r_cnt  <= 16'd0;
          r_wave <= ~r_wave;
        end else begin
          r_cnt  <= r_cnt + 16'd1;
        end
      end

      assign w_wave[gi]   = r_wave;
      assign w_active[gi] = (r_note != 4'd0);
    end
  endgenerate

  logic [MIX_W-1:0] w_pop;
  logic [MIX_W-1:0] r_mix;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_pop = w_pop + MIX_W'(w_wave[i]);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mix <= '0;
    end else begin
      r_mix <= w_pop;
    end
  end

  assign wave   = w_wave;
  assign active = w_active;
  assign mix    = r_mix;

endmodule

// File: tb/tb_note_voice_bank.sv
// Bench for note_voice_bank: per-cycle reference model plus a table of single-voice
// half-period vectors and directed multi-cycle sequences.
module tb_note_voice_bank;
  localparam int NV = 4;
  localparam int OW = 4;
  localparam int MW = $clog2(NV + 1);

  logic              clk = 1'b0;
  logic              nrst = 1'b1;
  logic              en = 1'b0;
  logic              is_FPGA = 1'b0;
  logic [4*NV-1:0]   note = '0;
  logic [OW*NV-1:0]  octave = '0;
  logic [NV-1:0]     wave;
  logic [NV-1:0]     active;
  logic [MW-1:0]     mix;

  int n_checks = 0;
  int n_errors = 0;

  note_voice_bank #(.NUM_VOICES(NV), .OCT_W(OW)) dut (
    .clk(clk), .nrst(nrst), .en(en), .is_FPGA(is_FPGA),
    .note(note), .octave(octave),
    .wave(wave), .active(active), .mix(mix)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each voice remembers when it was last loaded; the wave is then
  // just the parity of whole half-periods elapsed since that edge.
  int tab10[14] = '{0, 38223, 36077, 34052, 32141, 30337, 28635, 27027,
                    25511, 24079, 22727, 21452, 20248, 19111};
  int tab12[14] = '{0, 45868, 43292, 40862, 38569, 36404, 34362, 32432,
                    30613, 28895, 27272, 25742, 24298, 22933};

  int m_code[NV];
  int m_oct[NV];
  int m_sel[NV];
  int m_t0[NV];
  int m_n = 0;
  logic [NV-1:0] m_wave_prev = '0;

  function automatic int half_of(input int code, input int oc, input int sel);
    int t;
    int h;
    t = (sel != 0) ? tab12[code] : tab10[code];
    h = (t >> oc) >> 1;
    if (h == 0) h = 1;
    return h;
  endfunction

  always @(posedge clk) begin
    logic [NV-1:0] w_e;
    logic [NV-1:0] a_e;
    int mix_e;
    int eff;
    int oc;
    w_e = '0;
    a_e = '0;
    mix_e = 0;
    if (!nrst) begin
      for (int i = 0; i < NV; i++) begin
        m_code[i] = 0; m_oct[i] = 0; m_sel[i] = 0; m_t0[i] = 0;
      end
      m_wave_prev = '0;
    end else begin
      m_n++;
      mix_e = $countones(m_wave_prev);
      for (int i = 0; i < NV; i++) begin
        eff = int'(note[4*i +: 4]);
        if (!en || eff < 1 || eff > 13) eff = 0;
        oc = int'(octave[OW*i +: OW]);
        if (eff != m_code[i] || oc != m_oct[i] || int'(is_FPGA) != m_sel[i]) begin
          m_code[i] = eff;
          m_oct[i]  = oc;
          m_sel[i]  = int'(is_FPGA);
          m_t0[i]   = m_n;
        end
        a_e[i] = (m_code[i] != 0);
        if (a_e[i])
          w_e[i] = (((m_n - m_t0[i]) / half_of(m_code[i], m_oct[i], m_sel[i])) % 2) == 1;
      end
      m_wave_prev = w_e;
    end
    #1;
    check("model_wave", int'(wave), int'(w_e));
    check("model_active", int'(active), int'(a_e));
    check("model_mix", int'(mix), mix_e);
  end

  typedef struct {
    bit sel;
    int code;
    int oct;
    int half;
  } vec_t;

  vec_t tv[8];

  task automatic wait_wave0(input logic lvl, input int bound, output int m);
    m = 0;
    do begin
      @(posedge clk);
      #1;
      m++;
    end while (wave[0] !== lvl && m < bound);
  endtask

  task automatic load_voice0(input bit sel, input int code, input int oc);
    @(negedge clk);
    note = '0;
    octave = '0;
    en = 1'b1;
    @(negedge clk);
    is_FPGA = sel;
    note[3:0] = 4'(code);
    octave[OW-1:0] = OW'(oc);
  endtask

  initial begin
    int m;
    int bad[3] = '{0, 14, 15};

    tv[0] = '{1'b1, 10, 0, 13636};
    tv[1] = '{1'b0, 13, 2, 2388};
    tv[2] = '{1'b1, 13, 3, 1433};
    tv[3] = '{1'b0, 7, 3, 1689};
    tv[4] = '{1'b1, 5, 3, 2275};
    tv[5] = '{1'b0, 1, 13, 2};
    tv[6] = '{1'b0, 1, 14, 1};
    tv[7] = '{1'b0, 1, 15, 1};

    // Reset with notes present, then idle with en low.
    en = 1'b1;
    note = {4'd3, 4'd7, 4'd1, 4'd5};
    #1 nrst = 1'b0;
    #1;
    check("reset_wave", int'(wave), 0);
    check("reset_active", int'(active), 0);
    check("reset_mix", int'(mix), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    nrst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("idle_active", int'(active), 0);
    check("idle_wave", int'(wave), 0);

    // Single-voice half-period table.
    for (int i = 0; i < 8; i++) begin
      load_voice0(tv[i].sel, tv[i].code, tv[i].oct);
      @(posedge clk);
      #1;
      check("vec_active_at_load", int'(active[0]), 1);
      check("vec_wave_at_load", int'(wave[0]), 0);
      wait_wave0(1'b1, 2 * tv[i].half + 8, m);
      check("vec_first_rise", m, tv[i].half);
      wait_wave0(1'b0, 2 * tv[i].half + 8, m);
      check("vec_first_fall", m, tv[i].half);
    end

    // Octave change mid-note restarts the phase.
    load_voice0(1'b0, 13, 2);
    @(posedge clk);
    wait_wave0(1'b1, 5000, m);
    check("oct_rise", m, 2388);
    repeat (100) @(posedge clk);
    @(negedge clk);
    octave[OW-1:0] = '0;
    @(posedge clk);
    #1;
    check("oct_switch_drop", int'(wave[0]), 0);
    check("oct_switch_active", int'(active[0]), 1);
    wait_wave0(1'b1, 9600, m);
    check("oct_switch_rise", m, 9555);

    // Invalid codes silence a running voice on the next edge.
    foreach (bad[j]) begin
      load_voice0(1'b0, 1, 14);
      repeat (6) @(posedge clk);
      @(negedge clk);
      note[3:0] = 4'(bad[j]);
      @(posedge clk);
      #1;
      check("invalid_active", int'(active[0]), 0);
      check("invalid_wave", int'(wave[0]), 0);
      repeat (5) @(posedge clk);
      #1;
      check("invalid_hold", int'(wave[0]), 0);
    end

    // Four voices sounding together at 12 MHz.
    @(negedge clk);
    en = 1'b1;
    is_FPGA = 1'b1;
    note = {4'd13, 4'd8, 4'd5, 4'd1};
    octave = {4'd12, 4'd12, 4'd12, 4'd12};
    repeat (400) @(posedge clk);

    // Asynchronous reset while wave0 is high, then reload with the note held.
    load_voice0(1'b0, 13, 11);
    @(posedge clk);
    wait_wave0(1'b1, 100, m);
    check("rst_mid_rise", m, 4);
    #3 nrst = 1'b0;
    #1;
    check("rst_mid_wave", int'(wave), 0);
    check("rst_mid_mix", int'(mix), 0);
    check("rst_mid_active", int'(active), 0);
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_reload_active", int'(active[0]), 1);
    wait_wave0(1'b1, 100, m);
    check("rst_reload_rise", m, 4);

    // Randomised note/octave/clock-select/enable traffic against the model.
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      for (int v = 0; v < NV; v++) begin
        note[4*v +: 4]     = 4'($urandom_range(0, 15));
        octave[OW*v +: OW] = OW'($urandom_range(10, 15));
      end
      is_FPGA = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(5, 80)) @(posedge clk);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
